tx_serial: RTL and testbench

UART transmitter, the transmit counterpart of the team's serial receiver. It serializes one N_BITS word per request into the frame start(0), data LSB-first, parity, one stop bit(1) on txd, at BAUD_RATE derived from CLOCK_HZ. It pairs with the receiver so the two can run back-to-back in loopback benches and on the board link. Control is a UC-style FSM plus a datapath with a baud tick counter, a bit counter and a shift register.

---
 rtl/tx_serial.sv | 169 ++++++++++++++++
 tb/tb_tx_serial.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serial.sv
// tx_serial: UART transmitter.
// Sends one N_BITS word per accepted request as a frame on txd:
// start bit (0), data LSB-first, parity bit, one stop bit (1).
// Every line bit is held for TICKS = CLOCK_HZ / BAUD_RATE clock cycles.
//
// Ports:
//   clock      system clock, all logic on the rising edge
//   reset      synchronous active-high reset; aborts any frame in flight
//   partida    start request, only looked at while idle
//   data       word to send, latched on the cycle partida is accepted
//   txd        serial line, driven straight from a flop, idles high
//   busy       high from the cycle after acceptance through the DONE cycle
//   fim        one-cycle end-of-frame pulse
//   db_estado  current FSM state code (debug)
module tx_serial #(
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned CLOCK_HZ  = 50_000_000,
    parameter int unsigned N_BITS    = 8,
    parameter bit          PARITY    = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              partida,
    input  logic [N_BITS-1:0] data,
    output logic              txd,
    output logic              busy,
    output logic              fim,
    output logic [2:0]        db_estado
);

    // Clamp to one cycle per bit if the clock is slower than the baud rate.
    localparam int unsigned TICKS  = (CLOCK_HZ / BAUD_RATE > 0) ? (CLOCK_HZ / BAUD_RATE) : 1;
    localparam int unsigned TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [TICK_W-1:0] tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [N_BITS-1:0] shift;
    logic              par_bit;

    logic              tick_done_c;
    logic              accept_c;
    logic              timed_c;
    logic              txd_c;

    // Last cycle of the current line bit.
    assign tick_done_c = (tick_cnt == TICK_LAST);

    // A request is only honoured while idle; anything else is dropped.
    assign accept_c = (state == S_IDLE) && partida;

    // States that hold a line bit for TICKS cycles.
    assign timed_c = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; codes 6 and 7 fall back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (partida) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (tick_done_c) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_done_c && (bit_cnt == BIT_LAST)) begin
                    next_state = S_PARITY;
                end
            end
            S_PARITY: begin
                if (tick_done_c) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_done_c) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Baud tick counter: runs only while a line bit is being held.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (timed_c) begin
            tick_cnt <= tick_done_c ? '0 : (tick_cnt + TICK_W'(1));
        end else begin
            tick_cnt <= '0;
        end
    end

    // Word latch, parity and bit-serial shift.
    // Odd parity uses XNOR-reduction so data plus parity carries an odd count of ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else if (accept_c) begin
            shift   <= data;
            bit_cnt <= '0;
            par_bit <= PARITY ? ~^data : ^data;
        end else if ((state == S_DATA) && tick_done_c) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

    // Line level selected by the current state.
    always_comb begin
        txd_c = 1'b1;
        case (state)
            S_START:  txd_c = 1'b0;
            S_DATA:   txd_c = shift[0];
            S_PARITY: txd_c = par_bit;
            default:  txd_c = 1'b1;
        endcase
    end

    // Output flops: txd lags the state by one cycle, so txd falls the edge after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            txd  <= 1'b1;
            busy <= 1'b0;
            fim  <= 1'b0;
        end else begin
            txd  <= txd_c;
            busy <= timed_c || (state == S_DONE);
            fim  <= (state == S_DONE);
        end
    end

    assign db_estado = state;

endmodule

// File: tb/tb_tx_serial.sv
// Bench for tx_serial: two instances (odd and even parity) at TICKS = 10,
// checked cycle by cycle against a frame model built from the line format.
module tb_tx_serial;

    localparam int unsigned T     = 10;
    localparam int unsigned NB    = 8;
    localparam int unsigned FRAME = (NB + 3) * T;
    localparam int unsigned GAP   = FRAME + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       partida_o, partida_e;
    logic [7:0] data_o, data_e;
    logic       txd_o, busy_o, fim_o;
    logic       txd_e, busy_e, fim_e;
    logic [2:0] db_o, db_e;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tx_serial #(.BAUD_RATE(9600), .CLOCK_HZ(96000), .N_BITS(8), .PARITY(1'b1)) dut_odd (
        .clock(clk), .reset(reset), .partida(partida_o), .data(data_o),
        .txd(txd_o), .busy(busy_o), .fim(fim_o), .db_estado(db_o)
    );

    tx_serial #(.BAUD_RATE(9600), .CLOCK_HZ(96000), .N_BITS(8), .PARITY(1'b0)) dut_even (
        .clock(clk), .reset(reset), .partida(partida_e), .data(data_e),
        .txd(txd_e), .busy(busy_e), .fim(fim_e), .db_estado(db_e)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frame as line bits, index 0 first on the wire.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit odd);
        int   ones;
        logic p;
        ones = $countones(d);
        p    = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return {1'b1, p, d, 1'b0};
    endfunction

    // Expected line j cycles after the accepting edge.
    function automatic logic exp_line(input logic [10:0] fr, input int j);
        if (j >= 1 && j <= int'(FRAME)) return fr[(j - 1) / int'(T)];
        return 1'b1;
    endfunction

    // Expected state code j cycles after the accepting edge.
    function automatic logic [2:0] exp_state(input int j);
        if (j < int'(T))             return 3'd1;
        if (j < int'(9 * T))         return 3'd2;
        if (j < int'(10 * T))        return 3'd3;
        if (j < int'(FRAME))         return 3'd4;
        if (j == int'(FRAME))        return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic get_txd(input bit odd);
        return odd ? txd_o : txd_e;
    endfunction
    function automatic logic get_busy(input bit odd);
        return odd ? busy_o : busy_e;
    endfunction
    function automatic logic get_fim(input bit odd);
        return odd ? fim_o : fim_e;
    endfunction
    function automatic logic [2:0] get_db(input bit odd);
        return odd ? db_o : db_e;
    endfunction

    task automatic drive(input bit odd, input logic p, input logic [7:0] d);
        if (odd) begin
            partida_o = p;
            data_o    = d;
        end else begin
            partida_e = p;
            data_e    = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input bit odd, input logic [10:0] fr, input int j, input string tag);
        check($sformatf("%s_txd_j%0d", tag, j), 32'(get_txd(odd)), 32'(exp_line(fr, j)));
        check($sformatf("%s_state_j%0d", tag, j), 32'(get_db(odd)), 32'(exp_state(j)));
        check($sformatf("%s_busy_j%0d", tag, j), 32'(get_busy(odd)),
              32'((j >= 1) && (j <= int'(FRAME) + 1)));
        check($sformatf("%s_fim_j%0d", tag, j), 32'(get_fim(odd)), 32'(j == int'(FRAME) + 1));
    endtask

    // One frame; optionally a second request with other data lands mid-frame.
    task automatic run_frame(input bit odd, input logic [7:0] d, input bit poke, input string tag);
        logic [10:0] fr;
        fr = frame_bits(d, odd);
        drive(odd, 1'b1, d);
        step();
        drive(odd, 1'b0, ~d);
        check({tag, "_accept_state"}, 32'(get_db(odd)), 32'd1);
        check({tag, "_accept_txd"}, 32'(get_txd(odd)), 32'd1);
        for (int j = 1; j <= int'(FRAME) + 20; j++) begin
            step();
            check_cycle(odd, fr, j, tag);
            if (poke && j == 39) drive(odd, 1'b1, 8'hAA);
            if (poke && j == 40) drive(odd, 1'b0, 8'hAA);
        end
    endtask

    // partida held high across two frames with different words.
    task automatic run_b2b(input bit odd, input logic [7:0] d1, input logic [7:0] d2);
        logic [10:0] f1, f2;
        int          fims;
        int          jj;
        f1   = frame_bits(d1, odd);
        f2   = frame_bits(d2, odd);
        fims = 0;
        drive(odd, 1'b1, d1);
        step();
        drive(odd, 1'b1, d2);
        check("b2b_accept_state", 32'(get_db(odd)), 32'd1);
        for (int j = 1; j <= 2 * int'(GAP) + 15; j++) begin
            step();
            jj = (j < int'(GAP)) ? j : j - int'(GAP);
            check_cycle(odd, (j < int'(GAP)) ? f1 : f2, jj, "b2b");
            if (get_fim(odd)) fims++;
            if (j == int'(GAP)) drive(odd, 1'b0, d2);
        end
        check("b2b_fim_count", 32'(fims), 32'd2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        logic       rp, rs, rstart;
        bit         found, seen;
        logic [7:0] rd;
        bit         rodd;

        reset     = 1'b1;
        partida_o = 1'b0;
        partida_e = 1'b0;
        data_o    = 8'h00;
        data_e    = 8'h00;
        step();
        step();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 200; i++) begin
            check("idle_txd", 32'(txd_o), 32'd1);
            check("idle_busy", 32'(busy_o), 32'd0);
            check("idle_fim", 32'(fim_o), 32'd0);
            check("idle_state", 32'(db_o), 32'd0);
            check("idle_txd_even", 32'(txd_e), 32'd1);
            step();
        end

        // Directed frames: odd 41, even FF, odd 00.
        run_frame(1'b1, 8'h41, 1'b0, "odd41");
        run_frame(1'b0, 8'hFF, 1'b0, "evenFF");
        run_frame(1'b1, 8'h00, 1'b0, "odd00");

        // Request while busy is ignored.
        run_frame(1'b1, 8'h55, 1'b1, "busy55");

        // Back-to-back frames.
        run_b2b(1'b1, 8'h0F, 8'hF0);

        // Random words on random parity.
        for (int i = 0; i < 6; i++) begin
            rd   = 8'($urandom);
            rodd = 1'($urandom_range(1, 0));
            run_frame(rodd, rd, 1'b0, $sformatf("rand%0d", i));
        end

        // Reset during DATA, with partida high on the reset cycle.
        drive(1'b1, 1'b1, 8'h3C);
        step();
        drive(1'b1, 1'b0, 8'h3C);
        for (int j = 1; j <= 30; j++) step();
        check("pre_reset_state", 32'(db_o), 32'd2);
        reset     = 1'b1;
        partida_o = 1'b1;
        step();
        check("rst_txd", 32'(txd_o), 32'd1);
        check("rst_state", 32'(db_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_fim", 32'(fim_o), 32'd0);
        reset     = 1'b0;
        partida_o = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("post_rst_txd", 32'(txd_o), 32'd1);
            check("post_rst_state", 32'(db_o), 32'd0);
        end

        // Loopback: receive the line mid-bit and rebuild the word.
        drive(1'b1, 1'b1, 8'hC3);
        step();
        drive(1'b1, 1'b0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (txd_o === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("lb_start_found", 32'(found), 32'd1);
        if (found) begin
            repeat (T / 2 - 1) step();
            rstart = txd_o;
            check("lb_start_bit", 32'(rstart), 32'd0);
            rx = 8'h00;
            for (int i = 0; i < 8; i++) begin
                repeat (T) step();
                rx[i] = txd_o;
            end
            repeat (T) step();
            rp = txd_o;
            repeat (T) step();
            rs = txd_o;
            check("lb_data", 32'(rx), 32'hC3);
            check("lb_parity_ok", 32'(^{rx, rp}), 32'd1);
            check("lb_stop", 32'(rs), 32'd1);
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (fim_o === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("lb_fim", 32'(seen), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
